// File: rtl/lmx_pkg.sv
// rtl/lmx_pkg.sv - shared types and constants for the LMX SPI register loader
package lmx_pkg;

   localparam int LMX_WORD_W = 24;

   // R0 with RESET set, then R0 with RESET cleared (power-up prefix words)
   localparam logic [LMX_WORD_W-1:0] LMX_R0_RESET  = 24'h00201E;
   localparam logic [LMX_WORD_W-1:0] LMX_R0_NORMAL = 24'h00201C;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      FETCH,
      SHIFT,
      GAP,
      DONE
   } lmx_state_e;

endpackage

// File: rtl/spi_word_tx.sv
// rtl/spi_word_tx.sv - one 24-bit MSB-first SPI mode-0 write frame with CSB framing
module spi_word_tx
   import lmx_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [LMX_WORD_W-1:0] i_word,
   output logic                  o_done,
   output logic                  o_csb,
   output logic                  o_sck,
   output logic                  o_sdi
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   logic                  r_active;
   logic                  r_high;
   logic                  r_hold;
   logic                  r_csb;
   logic                  r_sck;
   logic [LMX_WORD_W-1:0] r_shift;
   logic [4:0]            r_bit;
   logic [15:0]           r_div;
   logic                  w_div_end;

   assign w_div_end = (r_div == DIV_LAST);
   // done coincides with the edge that raises CSB so the loader enters its gap together with it
   assign o_done    = r_active & r_hold & w_div_end;
   assign o_csb     = r_csb;
   assign o_sck     = r_sck;
   // the shift register MSB is the line; forced low outside a frame
   assign o_sdi     = ~r_csb & r_shift[LMX_WORD_W-1];

   // frame sequencer: low half, high half per bit, then one hold period before CSB rises
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_high   <= 1'b0;
         r_hold   <= 1'b0;
         r_csb    <= 1'b1;
         r_sck    <= 1'b0;
         r_shift  <= '0;
         r_bit    <= '0;
         r_div    <= '0;
      end else if (i_start && !r_active) begin
         r_active <= 1'b1;
         r_high   <= 1'b0;
         r_hold   <= 1'b0;
         r_csb    <= 1'b0;
         r_sck    <= 1'b0;
         r_shift  <= i_word;
         r_bit    <= 5'(LMX_WORD_W - 1);
         r_div    <= '0;
      end else if (r_active) begin
         if (!w_div_end) begin
            r_div <= r_div + 16'd1;
         end else begin
            r_div <= '0;
            if (r_hold) begin
               r_active <= 1'b0;
               r_hold   <= 1'b0;
               r_csb    <= 1'b1;
            end else if (!r_high) begin
               r_sck  <= 1'b1;
               r_high <= 1'b1;
            end else begin
               r_sck  <= 1'b0;
               r_high <= 1'b0;
               if (r_bit == 5'd0) begin
                  r_hold <= 1'b1;
               end else begin
                  r_bit   <= r_bit - 5'd1;
                  r_shift <= {r_shift[LMX_WORD_W-2:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/lmx_spi_loader.sv
// rtl/lmx_spi_loader.sv - walks the LMX register ROM and streams each word over SPI; LMX_POWERUP_RESET_EN adds an R0 reset prefix
module lmx_spi_loader
   import lmx_pkg::*;
#(
   parameter int N_REGS  = 126,
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   output logic [7:0]            o_reg_nr,
   input  logic [LMX_WORD_W-1:0] i_lmx_reg,
   output logic                  o_spi_csb,
   output logic                  o_spi_sck,
   output logic                  o_spi_sdi,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [7:0]  LAST_IDX = 8'(N_REGS - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   lmx_state_e            r_state;
   lmx_state_e            w_next;
   logic [7:0]            r_idx;
   logic [15:0]           r_gap;
   logic                  w_gap_end;
   logic                  w_tx_start;
   logic                  w_tx_done;
   logic                  w_in_prefix;
   logic [LMX_WORD_W-1:0] w_word;

`ifdef LMX_POWERUP_RESET_EN
   logic [1:0] r_pre;
   assign w_in_prefix = (r_pre != 2'd2);
   assign w_word      = (r_pre == 2'd0) ? LMX_R0_RESET :
                        (r_pre == 2'd1) ? LMX_R0_NORMAL : i_lmx_reg;

   // counts the two prefix frames; cleared at every accepted start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pre <= 2'd0;
      end else if (r_state == IDLE && i_start) begin
         r_pre <= 2'd0;
      end else if (r_state == GAP && w_gap_end && w_in_prefix) begin
         r_pre <= r_pre + 2'd1;
      end
   end
`else
   assign w_in_prefix = 1'b0;
   assign w_word      = i_lmx_reg;
`endif

   assign w_gap_end  = (r_gap == GAP_LAST);
   assign w_tx_start = (r_state == FETCH);
   assign o_reg_nr   = r_idx;
   assign o_busy     = (r_state != IDLE) && (r_state != DONE);
   assign o_done     = (r_state == DONE);

   spi_word_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (w_tx_start),
      .i_word  (w_word),
      .o_done  (w_tx_done),
      .o_csb   (o_spi_csb),
      .o_sck   (o_spi_sck),
      .o_sdi   (o_spi_sdi)
   );

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next state; the last-index compare happens before any increment so the index never wraps
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = ADDR;
         ADDR:    w_next = FETCH;
         FETCH:   w_next = SHIFT;
         SHIFT:   if (w_tx_done) w_next = GAP;
         GAP: begin
            if (w_gap_end) begin
               if (!w_in_prefix && r_idx == LAST_IDX) w_next = DONE;
               else                                   w_next = ADDR;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ROM index and inter-frame gap counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx <= 8'd0;
         r_gap <= 16'd0;
      end else if (r_state == GAP) begin
         if (w_gap_end) begin
            r_gap <= 16'd0;
            if (!w_in_prefix) begin
               r_idx <= (r_idx == LAST_IDX) ? 8'd0 : r_idx + 8'd1;
            end
         end else begin
            r_gap <= r_gap + 16'd1;
         end
      end else if (r_state == IDLE && i_start) begin
         r_idx <= 8'd0;
         r_gap <= 16'd0;
      end
   end

endmodule

// File: tb/tb_lmx_spi_loader.sv
// tb/tb_lmx_spi_loader.sv - directed self-checking bench for lmx_spi_loader
module tb_lmx_spi_loader;

   localparam int CLK_DIV   = 2;
   localparam int CS_GAP    = 3;
   localparam int N_FULL    = 126;
`ifdef LMX_POWERUP_RESET_EN
   localparam int PRE       = 2;
   localparam int N_SMALL   = 2;
`else
   localparam int PRE       = 0;
   localparam int N_SMALL   = 1;
`endif
   localparam int FRAME_LEN = 49 * CLK_DIV;
   localparam int DEPTH     = 512;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  start = 2'b00;
   logic [1:0]  csb, sck, sdi, busy, done;
   logic [7:0]  reg_nr0, reg_nr1;
   logic [23:0] rom_q0, rom_q1;

   int checks = 0;
   int errors = 0;

   logic [23:0] fr_word [2][DEPTH];
   int          fr_len  [2][DEPTH];
   int          fr_bits [2][DEPTH];
   int          fr_gap  [2][DEPTH];
   int          nfr     [2];
   int          ndone   [2];
   int          bd_err  [2];
   logic [23:0] sh      [2];
   int          nb      [2];
   int          low_run [2];
   int          hi_run  [2];
   logic [1:0]  prev_csb = 2'b11;
   logic [1:0]  prev_sck = 2'b00;

   always #5 clk = ~clk;

   function automatic logic [23:0] rom_f(input int i);
      case (i)
         0:       rom_f = 24'h7D2288;
         11:      rom_f = 24'h727802;
         125:     rom_f = 24'h00201C;
         default: rom_f = {8'(i) ^ 8'hA5, 8'(i * 3), ~8'(i)};
      endcase
   endfunction

   function automatic logic [23:0] exp_f(input int k);
      if (k < PRE) exp_f = (k == 0) ? 24'h00201E : 24'h00201C;
      else         exp_f = rom_f(k - PRE);
   endfunction

   always @(posedge clk) begin
      rom_q0 <= rom_f(int'(reg_nr0));
      rom_q1 <= rom_f(int'(reg_nr1));
   end

   lmx_spi_loader #(.N_REGS(N_FULL), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .o_reg_nr(reg_nr0),
      .i_lmx_reg(rom_q0), .o_spi_csb(csb[0]), .o_spi_sck(sck[0]), .o_spi_sdi(sdi[0]),
      .o_busy(busy[0]), .o_done(done[0]));

   lmx_spi_loader #(.N_REGS(N_SMALL), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .o_reg_nr(reg_nr1),
      .i_lmx_reg(rom_q1), .o_spi_csb(csb[1]), .o_spi_sck(sck[1]), .o_spi_sdi(sdi[1]),
      .o_busy(busy[1]), .o_done(done[1]));

   // SPI slave model and frame/gap timing monitor for both instances
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!csb[g]) begin
            if (prev_csb[g]) begin
               if (nfr[g] < DEPTH) fr_gap[g][nfr[g]] = hi_run[g];
               nb[g] = 0; sh[g] = 24'd0; low_run[g] = 0;
            end
            low_run[g]++;
            if (sck[g] && !prev_sck[g]) begin
               sh[g] = {sh[g][22:0], sdi[g]};
               nb[g]++;
            end
         end else begin
            if (!prev_csb[g] && nfr[g] < DEPTH) begin
               fr_word[g][nfr[g]] = sh[g];
               fr_bits[g][nfr[g]] = nb[g];
               fr_len[g][nfr[g]]  = low_run[g];
               nfr[g]++;
               hi_run[g] = 0;
            end
            if (busy[g]) hi_run[g]++;
            else         hi_run[g] = 0;
         end
         if (done[g]) begin
            ndone[g]++;
            if (busy[g]) bd_err[g]++;
         end
         prev_csb[g] = csb[g];
         prev_sck[g] = sck[g];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input int g);
      @(posedge clk); #1 start[g] = 1'b1;
      @(posedge clk); #1 start[g] = 1'b0;
   endtask

   initial begin
      int base;
      int d0;
      int bad;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset and idle
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_pins", {csb, sck, sdi, busy, done}, 10'b11_00_00_00_00);
      end
      chk("idle_reg_nr", {reg_nr0, reg_nr1}, 16'h0000);

      // single frame (plus prefix when enabled)
      base = nfr[1];
      pulse_start(1);
      @(negedge clk);
      chk("single_busy", busy[1], 1'b1);
      for (int c = 0; c < 5000 && ndone[1] == 0; c++) @(negedge clk);
      chk("single_done_seen", ndone[1], 1);
      repeat (20) @(negedge clk);
      chk("single_frames", nfr[1] - base, N_SMALL + PRE);
      for (int k = 0; k < N_SMALL + PRE; k++) begin
         chk("single_word", fr_word[1][base + k], exp_f(k));
         chk("single_bits", fr_bits[1][base + k], 24);
         chk("single_len", fr_len[1][base + k], FRAME_LEN);
      end
      chk("single_done_once", ndone[1], 1);
      chk("single_busy_on_done", bd_err[1], 0);
      chk("single_idle_after", {busy[1], csb[1]}, 2'b01);

      // full sequence with an ignored second start in frame 40
      base = nfr[0];
      d0   = ndone[0];
      pulse_start(0);
      for (int c = 0; c < 20000 && nfr[0] - base < 40 + PRE; c++) @(negedge clk);
      chk("full_reach_40", nfr[0] - base >= 40 + PRE, 1'b1);
      for (int c = 0; c < 50 && csb[0]; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      pulse_start(0);
      for (int c = 0; c < 40000 && ndone[0] == d0; c++) @(negedge clk);
      chk("full_done_seen", ndone[0] - d0, 1);
      repeat (60) @(negedge clk);
      chk("full_frames", nfr[0] - base, N_FULL + PRE);
      chk("full_first", fr_word[0][base + PRE], 24'h7D2288);
      chk("full_idx11", fr_word[0][base + PRE + 11], 24'h727802);
      chk("full_last", fr_word[0][base + PRE + N_FULL - 1], 24'h00201C);
      bad = 0;
      for (int k = 0; k < N_FULL + PRE; k++) begin
         if (fr_word[0][base + k] !== exp_f(k) || fr_bits[0][base + k] != 24 ||
             fr_len[0][base + k] != FRAME_LEN) bad++;
      end
      chk("full_frame_errs", bad, 0);
      bad = 0;
      for (int k = 1; k < N_FULL + PRE; k++) if (fr_gap[0][base + k] < CS_GAP) bad++;
      chk("full_gap_errs", bad, 0);
      chk("full_done_once", ndone[0] - d0, 1);
      chk("full_busy_on_done", bd_err[0], 0);
      chk("full_end_state", {busy[0], csb[0], reg_nr0}, {2'b01, 8'h00});

      // reset during bit 10 of frame 5
      base = nfr[0];
      pulse_start(0);
      for (int c = 0; c < 5000 && !(nfr[0] - base == 5 + PRE && !csb[0] && nb[0] == 13 && !sck[0]); c++)
         @(negedge clk);
      chk("rst_reach_bit10", {csb[0], 5'(nb[0])}, {1'b0, 5'd13});
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_pins", {csb[0], sck[0], sdi[0], busy[0], done[0]}, 5'b10000);
      chk("rst_async_reg_nr", reg_nr0, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_partial_frame", fr_bits[0][nfr[0] - 1] < 24, 1'b1);
      base = nfr[0];
      pulse_start(0);
      for (int c = 0; c < 5000 && nfr[0] - base < PRE + 2; c++) @(negedge clk);
      chk("restart_frames", nfr[0] - base >= PRE + 2, 1'b1);
      for (int k = 0; k < PRE + 2; k++) chk("restart_word", fr_word[0][base + k], exp_f(k));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
